// File: rtl/key_scan_sched_if.sv
// Pin-side and consumer-side signals of the key scanner; master = scanner, slave = consumer.
// KEY_RELEASE_FLAG_EN adds the key_rel_flag release-pulse vector.
interface key_scan_sched_if #(
    parameter int NUM_KEYS = 4
) ();
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_flag;
    logic [NUM_KEYS-1:0] key_state;
    logic                scan_busy;
`ifdef KEY_RELEASE_FLAG_EN
    logic [NUM_KEYS-1:0] key_rel_flag;
`endif

    modport master (
        input  key_in,
        output key_flag,
        output key_state,
        output scan_busy
`ifdef KEY_RELEASE_FLAG_EN
        ,
        output key_rel_flag
`endif
    );

    modport slave (
        output key_in,
        input  key_flag,
        input  key_state,
        input  scan_busy
`ifdef KEY_RELEASE_FLAG_EN
        ,
        input  key_rel_flag
`endif
    );
endinterface

// File: rtl/key_scan_sched.sv
// Round-robin debouncer: one prescaler tick starts a scan visiting one key per clock through a
// single shared comparator/counter. Optional KEY_RELEASE_FLAG_EN adds release pulses.
module key_scan_sched #(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    key_scan_sched_if.master bus
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CNT_W = $clog2(STABLE_TICKS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
        $error("NUM_KEYS must be in 1..16");
    end
    if (TICK_DIV <= NUM_KEYS + 1) begin : g_bad_tick_div
        $error("TICK_DIV must exceed NUM_KEYS + 1");
    end
    if (STABLE_TICKS < 2 || STABLE_TICKS > 255) begin : g_bad_stable_ticks
        $error("STABLE_TICKS must be in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_LAST) ? c : c + CNT_W'(1);
    endfunction

    // ---- Stage p0/p1: two-flop synchroniser, idle-high ----
    logic [NUM_KEYS-1:0] key_meta_p0;
    logic [NUM_KEYS-1:0] key_sync_p1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_meta_p0 <= '1;
            key_sync_p1 <= '1;
        end else begin
            key_meta_p0 <= bus.key_in;
            key_sync_p1 <= key_meta_p0;
        end
    end

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             vld_p1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vld_p1  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                vld_p1 = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    assign bus.scan_busy = (state_q == SCAN);

    // ---- Stage p1: shared comparator / incrementer for the visited key ----
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_lvl_p2;
    logic                sync_sel_p1;
    logic                lvl_sel_p1;
    logic [CNT_W-1:0]    cnt_sel_p1;
    logic                mismatch_p1;
    logic                accept_p1;
    logic [CNT_W-1:0]    cnt_nxt_p1;

    assign sync_sel_p1 = key_sync_p1[idx_q];
    assign lvl_sel_p1  = key_lvl_p2[idx_q];
    assign cnt_sel_p1  = cnt_q[idx_q];
    assign mismatch_p1 = (sync_sel_p1 != lvl_sel_p1);
    assign accept_p1   = vld_p1 && mismatch_p1 && (cnt_sel_p1 == CNT_LAST);
    assign cnt_nxt_p1  = (!mismatch_p1 || accept_p1) ? '0 : cnt_sat_inc(cnt_sel_p1);

    // ---- Stage p2: committed levels and one-cycle pulses ----
    logic [NUM_KEYS-1:0] flag_p2;
`ifdef KEY_RELEASE_FLAG_EN
    logic [NUM_KEYS-1:0] rel_flag_p2;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            key_lvl_p2 <= '1;
            flag_p2    <= '0;
`ifdef KEY_RELEASE_FLAG_EN
            rel_flag_p2 <= '0;
`endif
        end else begin
            flag_p2 <= '0;
`ifdef KEY_RELEASE_FLAG_EN
            rel_flag_p2 <= '0;
`endif
            if (vld_p1) begin
                cnt_q[idx_q] <= cnt_nxt_p1;
                if (accept_p1) begin
                    key_lvl_p2[idx_q] <= sync_sel_p1;
                    if (!sync_sel_p1) begin
                        flag_p2[idx_q] <= 1'b1;
                    end
`ifdef KEY_RELEASE_FLAG_EN
                    if (sync_sel_p1) begin
                        rel_flag_p2[idx_q] <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    assign bus.key_flag  = flag_p2;
    assign bus.key_state = key_lvl_p2;
`ifdef KEY_RELEASE_FLAG_EN
    assign bus.key_rel_flag = rel_flag_p2;
`endif

endmodule
